// File: rtl/chnl_trig_smpl.sv
// Comparator-pair channel resolver with hysteresis, decimation and an
// arm/trigger/post-trigger capture sequencer feeding the capture RAM writer.
module chnl_trig_smpl #(
   parameter int unsigned POST_W = 9,
   parameter int unsigned DEC_W  = 4
) (
   input  logic              smpl_clk,
   input  logic              rst_n,
   input  logic              CH1L,
   input  logic              CH1H,
   input  logic              CH2L,
   input  logic              CH2H,
   input  logic              CH3L,
   input  logic              CH3H,
   input  logic              CH4L,
   input  logic              CH4H,
   input  logic              CH5L,
   input  logic              CH5H,
   input  logic [DEC_W-1:0]  decimator,
   input  logic [2:0]        trig_src,
   input  logic              trig_pos_edge,
   input  logic [POST_W-1:0] post_cnt,
   input  logic              arm,
   output logic [4:0]        smpl,
   output logic              smpl_vld,
   output logic              armed,
   output logic              triggered,
   output logic              capt_done,
   output logic              thr_err
);

   localparam int unsigned CntW = (1 << DEC_W) - 1;

   typedef enum logic [1:0] {StIdle, StArmed, StPost, StDone} state_e;

   logic [4:0]        l_raw, h_raw;
   logic [4:0]        l_s1_q, l_s2_q, h_s1_q, h_s2_q;
   logic [4:0]        level_q, level_d;
   logic              thr_err_q, thr_err_d;
   logic [4:0]        smpl_q, smpl_d;
   logic              smpl_vld_q, smpl_vld_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [CntW-1:0]   dec_mask;
   logic              strb;
   logic [POST_W-1:0] post_q, post_d;
   logic              triggered_q, triggered_d;
   state_e            state_q, state_d;
   logic              sel_prev, sel_next, trig_forced, trig_hit;

   assign l_raw = {CH5L, CH4L, CH3L, CH2L, CH1L};
   assign h_raw = {CH5H, CH4H, CH3H, CH2H, CH1H};

   // Hysteresis band holds the level; an inverted pair holds and flags.
   always_comb begin
      level_d   = level_q;
      thr_err_d = thr_err_q;
      for (int i = 0; i < 5; i++) begin
         if (h_s2_q[i] && l_s2_q[i]) begin
            level_d[i] = 1'b1;
         end else if (!h_s2_q[i] && !l_s2_q[i]) begin
            level_d[i] = 1'b0;
         end else if (h_s2_q[i] && !l_s2_q[i]) begin
            thr_err_d = 1'b1;
         end
      end
   end

   always_comb begin
      dec_mask = '0;
      for (int i = 0; i < CntW; i++) begin
         dec_mask[i] = (i < int'(decimator));
      end
   end

   assign strb   = &(cnt_q | ~dec_mask);
   assign smpl_d = strb ? level_d : smpl_q;

   always_comb begin
      sel_prev    = 1'b0;
      sel_next    = 1'b0;
      trig_forced = 1'b0;
      case (trig_src)
         3'd1:    begin sel_prev = smpl_q[0]; sel_next = smpl_d[0]; end
         3'd2:    begin sel_prev = smpl_q[1]; sel_next = smpl_d[1]; end
         3'd3:    begin sel_prev = smpl_q[2]; sel_next = smpl_d[2]; end
         3'd4:    begin sel_prev = smpl_q[3]; sel_next = smpl_d[3]; end
         3'd5:    begin sel_prev = smpl_q[4]; sel_next = smpl_d[4]; end
         default: trig_forced = 1'b1;
      endcase
   end

   assign trig_hit = trig_forced ||
                     (trig_pos_edge ? (!sel_prev && sel_next) : (sel_prev && !sel_next));

   always_comb begin
      state_d     = state_q;
      post_d      = post_q;
      triggered_d = triggered_q;
      cnt_d       = cnt_q + CntW'(1);
      smpl_vld_d  = 1'b0;
      case (state_q)
         StIdle, StDone: begin
            if (arm) begin
               state_d     = StArmed;
               triggered_d = 1'b0;
               cnt_d       = '0;
            end
         end
         StArmed: begin
            if (strb) begin
               smpl_vld_d = 1'b1;
               if (trig_hit) begin
                  triggered_d = 1'b1;
                  post_d      = post_cnt;
                  state_d     = (post_cnt == '0) ? StDone : StPost;
               end
            end
         end
         StPost: begin
            if (strb) begin
               smpl_vld_d = 1'b1;
               post_d     = post_q - POST_W'(1);
               if (post_q == POST_W'(1)) begin
                  state_d = StDone;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge smpl_clk) begin
      if (!rst_n) begin
         l_s1_q      <= '0;
         l_s2_q      <= '0;
         h_s1_q      <= '0;
         h_s2_q      <= '0;
         level_q     <= '0;
         thr_err_q   <= 1'b0;
         smpl_q      <= '0;
         smpl_vld_q  <= 1'b0;
         cnt_q       <= '0;
         post_q      <= '0;
         triggered_q <= 1'b0;
         state_q     <= StIdle;
      end else begin
         l_s1_q      <= l_raw;
         l_s2_q      <= l_s1_q;
         h_s1_q      <= h_raw;
         h_s2_q      <= h_s1_q;
         level_q     <= level_d;
         thr_err_q   <= thr_err_d;
         smpl_q      <= smpl_d;
         smpl_vld_q  <= smpl_vld_d;
         cnt_q       <= cnt_d;
         post_q      <= post_d;
         triggered_q <= triggered_d;
         state_q     <= state_d;
      end
   end

   assign smpl      = smpl_q;
   assign smpl_vld  = smpl_vld_q;
   assign armed     = (state_q == StArmed);
   assign triggered = triggered_q;
   assign capt_done = (state_q == StDone);
   assign thr_err   = thr_err_q;

endmodule
